// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: the FSM state
// encoding, the word-length select encodings and a helper that turns the
// word-length select into a bit count.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Number of data bits carried by a frame for a given word-length select.
  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    logic [3:0] bits;
    case (wls)
      WLS_5:   bits = 4'd5;
      WLS_6:   bits = 4'd6;
      WLS_7:   bits = 4'd7;
      default: bits = 4'd8;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: synchronises the asynchronous rx line,
// runs the per-bit oversampling tick counter and produces one bit decision
// per bit period.
// Build option UART_RX_MAJORITY_EN: when defined, each bit decision is the
// 2-of-3 majority of the synchronised line at ticks mid-1, mid and mid+1,
// presented at tick mid+1; otherwise a single sample at tick mid is used.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick_i,
  input  logic rx_i,
  input  logic run_i,
  output logic rxs_o,
  output logic sample_o,
  output logic sample_strobe_o,
  output logic bit_end_o
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;

  // Metastability synchroniser; idles at the line's mark level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs_o = sync_q[SYNC_STAGES-1];

  // Tick position within the current bit; held at 0 whenever the FSM is idle
  // so the first tick after start detection is tick 0 of the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (!run_i)      cnt_q <= '0;
    else if (baud_tick_i) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] VOTE_A      = CW'(OVS / 2 - 2);
  localparam logic [CW-1:0] VOTE_B      = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] STROBE_TICK = CW'(OVS / 2);

  logic vote_a_q;
  logic vote_b_q;

  // Capture the two earlier votes; the third is the live line at the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
    end else if (run_i && baud_tick_i) begin
      if (cnt_q == VOTE_A) vote_a_q <= rxs_o;
      if (cnt_q == VOTE_B) vote_b_q <= rxs_o;
    end
  end

  assign sample_o = (vote_a_q & vote_b_q) | (vote_a_q & rxs_o) | (vote_b_q & rxs_o);
`else
  localparam logic [CW-1:0] STROBE_TICK = CW'(OVS / 2 - 1);

  assign sample_o = rxs_o;
`endif

  assign sample_strobe_o = run_i & baud_tick_i & (cnt_q == STROBE_TICK);
  assign bit_end_o       = run_i & baud_tick_i & (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_ovs.sv
// Parametrised 16550-style UART receiver: 5-8 data bits LSB first, optional
// odd/even/stick parity, 1 or 2 stop bits, break detection and a valid/ready
// output with overrun reporting.
// Build option UART_RX_MAJORITY_EN selects 3-sample majority voting inside
// uart_rx_sampler; the default build samples once per bit.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       stb,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       oe,
  output logic       rx_busy
);

  rx_state_e  state_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       par_bit_q;
  logic       fe_frame_q;
  logic       stop_idx_q;
  logic       brk_wait_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       pe_q;
  logic       fe_q;
  logic       bi_q;
  logic       oe_q;

  logic       rxs;
  logic       sample;
  logic       sample_strobe;
  logic       bit_end;
  logic [3:0] word_bits;
  logic       last_bit;
  logic       frame_done;
  logic       accept;
  logic       fe_d;
  logic       pe_d;
  logic       bi_d;

  uart_rx_sampler #(
    .OVS         (OVS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .baud_tick_i     (baud_tick),
    .rx_i            (rx),
    .run_i           (state_q != IDLE),
    .rxs_o           (rxs),
    .sample_o        (sample),
    .sample_strobe_o (sample_strobe),
    .bit_end_o       (bit_end)
  );

  assign word_bits  = wls_to_bits(wls);
  assign last_bit   = ({1'b0, bit_idx_q} == (word_bits - 4'd1));
  // The frame ends at the decision point of the last stop bit, not its end.
  assign frame_done = (state_q == STOP) & sample_strobe & (~stb | stop_idx_q);
  assign accept     = rx_valid_q & rx_ready;

  // Frame status; with two stop bits only the first one decides framing.
  assign fe_d = stop_idx_q ? fe_frame_q : ~sample;
  // Stick parity expects ~eps; otherwise the data+parity XOR must equal ~eps.
  assign pe_d = pen & (sticky_parity ? (par_bit_q == eps)
                                     : ((^shift_q ^ par_bit_q) == eps));
  assign bi_d = (shift_q == 8'd0) & (~pen | ~par_bit_q) & fe_d;

  // Receive FSM plus the output holding register and its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      fe_frame_q <= 1'b0;
      stop_idx_q <= 1'b0;
      brk_wait_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // After a break the line must return to mark before a new start
          // edge is trusted, so a long break yields exactly one frame.
          if (baud_tick) begin
            if (rxs)              brk_wait_q <= 1'b0;
            else if (!brk_wait_q) state_q    <= START;
          end
        end
        START: begin
          if (sample_strobe && sample) begin
            state_q <= IDLE;
          end else if (bit_end) begin
            state_q    <= DATA;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            stop_idx_q <= 1'b0;
          end
        end
        DATA: begin
          if (sample_strobe) shift_q[bit_idx_q] <= sample;
          if (bit_end) begin
            if (last_bit) state_q   <= pen ? PARITY : STOP;
            else          bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        PARITY: begin
          if (sample_strobe) par_bit_q <= sample;
          if (bit_end)       state_q   <= STOP;
        end
        STOP: begin
          if (sample_strobe && !stop_idx_q) fe_frame_q <= ~sample;
          if (frame_done) begin
            state_q    <= IDLE;
            brk_wait_q <= bi_d;
          end else if (bit_end) begin
            stop_idx_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      oe_q <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          pe_q       <= pe_d;
          fe_q       <= fe_d;
          bi_q       <= bi_d;
          rx_valid_q <= 1'b1;
        end else begin
          oe_q <= 1'b1;
        end
      end else if (accept) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign pe       = pe_q;
  assign fe       = fe_q;
  assign bi       = bi_q;
  assign oe       = oe_q;
  assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed frames from the test plan
// plus randomised frames, each checked against a frame-level reference model
// that derives the expected word and status flags from the bits put on the
// line.
module tb_uart_rx_ovs;

  localparam int OVS  = 16;
  localparam int TDIV = 3;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic       stb;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       oe;
  logic       rx_busy;

  int   divCnt     = 0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   validCount = 0;
  int   oeCount    = 0;
  int   expFrames  = 0;
  exp_t expQ[$];

  uart_rx_ovs #(
    .OVS         (OVS),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .wls           (wls),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stb           (stb),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .pe            (pe),
    .fe            (fe),
    .bi            (bi),
    .oe            (oe),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) divCnt <= (divCnt == TDIV - 1) ? 0 : divCnt + 1;
  assign baud_tick = (divCnt == 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard: every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (oe === 1'b1) oeCount++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      validCount++;
      checkOutput("frame_expected", (expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rx_data", rx_data, e.data);
        checkOutput("pe", pe, e.pe);
        checkOutput("fe", fe, e.fe);
        checkOutput("bi", bi, e.bi);
      end
    end
  end

  task automatic waitTick();
    @(posedge clk);
    while (baud_tick !== 1'b1) @(posedge clk);
  endtask

  task automatic holdLevel(input logic level, input int ticks);
    rx = level;
    repeat (ticks) waitTick();
    #2;
  endtask

  // Puts one frame on the line using the current configuration and, when
  // asked, records what the receiver should report for it.
  task automatic applyStimulus(input logic [7:0] data, input logic parFlip,
                               input logic stop1, input logic stop2,
                               input logic wantCheck);
    int         n;
    logic [7:0] mask;
    logic [7:0] masked;
    logic       goodPar;
    logic       parBit;
    exp_t       e;
    n       = 5 + int'(wls);
    mask    = 8'hFF >> (8 - n);
    masked  = data & mask;
    goodPar = sticky_parity ? ~eps : (eps ? ^masked : ~(^masked));
    parBit  = goodPar ^ parFlip;
    if (wantCheck) begin
      e.data = masked;
      e.pe   = pen & parFlip;
      e.fe   = ~stop1;
      e.bi   = (masked == 8'd0) && (!pen || !parBit) && !stop1;
      expQ.push_back(e);
      expFrames++;
    end
    holdLevel(1'b0, OVS);
    for (int i = 0; i < n; i++) holdLevel(data[i], OVS);
    if (pen) holdLevel(parBit, OVS);
    holdLevel(stop1, OVS);
    if (stb) holdLevel(stop2, OVS);
  endtask

  task automatic setConfig(input logic [1:0] w, input logic p, input logic e,
                           input logic s, input logic b);
    wls = w; pen = p; eps = e; sticky_parity = s; stb = b;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   oeBase;
    int   validBase;
    logic [7:0] data;
    logic parFlip;
    logic stop1;

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    setConfig(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("reset_outputs", {rx_data, rx_valid, pe, fe, bi, oe, rx_busy}, 0);
    rst = 1'b0;
    waitTick();
    #2;
    holdLevel(1'b1, OVS);

    // 8N1 basic word.
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);
    checkOutput("a5_frames", validCount, expFrames);

    // 7E1 with wrong then correct parity.
    setConfig(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h35, 1'b1, 1'b1, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);
    applyStimulus(8'h35, 1'b0, 1'b1, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);

    // 8N2: first stop low flags framing, second stop low does not.
    setConfig(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    holdLevel(1'b1, OVS);
    checkOutput("stb_idle_busy", rx_busy, 0);
    checkOutput("stb_frames", validCount, expFrames);

    // Long break: exactly one all-zero frame with bi and fe.
    setConfig(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1});
    expFrames++;
    holdLevel(1'b0, 12 * OVS);
    holdLevel(1'b1, 2 * OVS);
    checkOutput("break_frames", validCount, expFrames);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);

    // Short start glitch is rejected.
    validBase = validCount;
    holdLevel(1'b0, 4);
    checkOutput("glitch_busy", rx_busy, 1);
    holdLevel(1'b1, OVS);
    checkOutput("glitch_idle", rx_busy, 0);
    checkOutput("glitch_no_frame", validCount, validBase);

`ifdef UART_RX_MAJORITY_EN
    // Single-tick glitch at the decision point of data bit 3 is outvoted.
    expQ.push_back('{data: 8'hFF, pe: 1'b0, fe: 1'b0, bi: 1'b0});
    expFrames++;
    holdLevel(1'b0, OVS);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        holdLevel(1'b1, 8);
        holdLevel(1'b0, 1);
        holdLevel(1'b1, OVS - 9);
      end else begin
        holdLevel(1'b1, OVS);
      end
    end
    holdLevel(1'b1, 2 * OVS);
    checkOutput("majority_frames", validCount, expFrames);
`endif

    // Randomised frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      setConfig(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      data    = 8'($urandom_range(0, 255));
      parFlip = pen ? 1'($urandom_range(0, 1)) : 1'b0;
      stop1   = ($urandom_range(0, 4) != 0);
      applyStimulus(data, parFlip, stop1, 1'b1, 1'b1);
      if (!stop1 || $urandom_range(0, 1) == 1) holdLevel(1'b1, OVS);
    end
    holdLevel(1'b1, OVS);
    checkOutput("random_frames", validCount, expFrames);

    // Overrun: held word survives, one single-clock oe pulse.
    setConfig(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    holdLevel(1'b1, OVS);
    checkOutput("ovr_valid", rx_valid, 1);
    checkOutput("ovr_first", rx_data, 8'h11);
    oeBase = oeCount;
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    holdLevel(1'b1, OVS);
    checkOutput("ovr_held", rx_data, 8'h11);
    checkOutput("ovr_oe_clocks", oeCount - oeBase, 1);
    expQ.push_back('{data: 8'h11, pe: 1'b0, fe: 1'b0, bi: 1'b0});
    expFrames++;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("ovr_drained", rx_valid, 0);

    // Reset in the middle of 0x33 aborts without any report.
    waitTick();
    #2;
    validBase = validCount;
    oeBase = oeCount;
    holdLevel(1'b0, OVS);
    holdLevel(1'b1, OVS);
    holdLevel(1'b1, OVS);
    checkOutput("rst_busy_before", rx_busy, 1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_outputs", {rx_valid, oe, rx_busy}, 0);
    rst = 1'b0;
    waitTick();
    #2;
    holdLevel(1'b1, 3 * OVS);
    checkOutput("rst_no_frame", validCount, validBase);
    checkOutput("rst_no_oe", oeCount, oeBase);
    checkOutput("rst_idle", rx_busy, 0);
    applyStimulus(8'h33, 1'b0, 1'b1, 1'b1, 1'b1);
    holdLevel(1'b1, OVS);

    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("frames_total", validCount, expFrames);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
